// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//
// Flow-controlled pipeline stage register with a two-entry skid buffer.
// A valid/ready handshake replaces a global stall. Both in_ready and out_valid
// come straight from flops, so back-pressure never forms a combinational path
// from one stage to the next. Flush empties the stage and zeroes the payload
// bits selected by CLR_MASK, for example to force an instruction word to NOP.
//
// Parameters:
//   WIDTH     payload width in bits (>= 1)
//   CLR_MASK  payload bits zeroed in both data registers on flush
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset; clears everything
//   flush      synchronous flush; lower priority than rst, higher than handshakes
//   in_valid   upstream presents in_data
//   in_ready   stage can accept a word (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a valid word (registered)
//   out_ready  downstream takes out_data this cycle
//   out_data   payload to downstream, driven by the main register
//   count      occupancy, 0..2
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] CLR_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Main register feeds the output; the skid register catches the word that
  // arrives while the main register is stalled.
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_main_valid;
  logic             r_skid_valid;

  logic [WIDTH-1:0] w_main_data_next;
  logic [WIDTH-1:0] w_skid_data_next;
  logic             w_main_valid_next;
  logic             w_skid_valid_next;

  logic [WIDTH-1:0] w_main_flushed;
  logic [WIDTH-1:0] w_skid_flushed;

  logic             w_in_fire;
  logic             w_out_fire;

  // in_ready only drops once the skid register is occupied, which is what
  // keeps it registered rather than a function of out_ready.
  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign count      = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  assign w_in_fire  = in_valid & ~r_skid_valid;
  assign w_out_fire = r_main_valid & out_ready;

  // Flush values: masked bits are cleared, the rest keep their contents.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_flush_mask
      assign w_main_flushed[gi] = CLR_MASK[gi] ? 1'b0 : r_main_data[gi];
      assign w_skid_flushed[gi] = CLR_MASK[gi] ? 1'b0 : r_skid_data[gi];
    end
  endgenerate

  always_comb begin
    w_main_data_next  = r_main_data;
    w_skid_data_next  = r_skid_data;
    w_main_valid_next = r_main_valid;
    w_skid_valid_next = r_skid_valid;

    if (flush) begin
      // Handshakes in the flush cycle are ignored; in-flight words are dropped.
      w_main_valid_next = 1'b0;
      w_skid_valid_next = 1'b0;
      w_main_data_next  = w_main_flushed;
      w_skid_data_next  = w_skid_flushed;
    end else if (!r_main_valid) begin
      // EMPTY (skid is never valid without main)
      if (w_in_fire) begin
        w_main_data_next  = in_data;
        w_main_valid_next = 1'b1;
      end
    end else if (!r_skid_valid) begin
      // ONE
      unique case ({w_in_fire, w_out_fire})
        2'b11: w_main_data_next = in_data;
        2'b10: begin
          w_skid_data_next  = in_data;
          w_skid_valid_next = 1'b1;
        end
        2'b01: w_main_valid_next = 1'b0;
        default: ;
      endcase
    end else begin
      // FULL: in_ready is low, so only a drain can happen.
      if (w_out_fire) begin
        w_main_data_next  = r_skid_data;
        w_skid_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_data  <= '0;
      r_skid_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_data  <= w_main_data_next;
      r_skid_data  <= w_skid_data_next;
      r_main_valid <= w_main_valid_next;
      r_skid_valid <= w_skid_valid_next;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  count;

  int checks;
  int errors;

  logic [15:0] sb_q[$];

  elastic_pipe_reg #(
    .WIDTH   (16),
    .CLR_MASK(16'hFF00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        exp_ov;
    logic        exp_ir;
    logic [15:0] exp_od;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [15:0] d, input logic o,
                              input logic eov, input logic eir,
                              input logic [15:0] eod, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
    v.exp_ov = eov; v.exp_ir = eir; v.exp_od = eod; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scoreboard cycle: drive inputs, account for the transfers the DUT
  // will perform at the next edge, then check state against the queue model.
  task automatic sb_step(input logic iv, input logic [15:0] d, input logic o, input logic fl);
    logic        in_fire;
    logic        out_fire;
    logic [15:0] exp_word;
    rst       = 1'b0;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = o;
    in_fire   = iv & in_ready;
    out_fire  = out_valid & o;
    if (out_fire && !fl) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_word = sb_q.pop_front();
        chk("sb_out_data", {16'h0, out_data}, {16'h0, exp_word});
        $display("xfer out=%04h expected=%04h", out_data, exp_word);
      end
    end
    if (fl) sb_q.delete();
    else if (in_fire) sb_q.push_back(d);
    tick();
    chk("sb_count", {30'h0, count}, sb_q.size());
    chk("sb_out_valid", {31'h0, out_valid}, {31'h0, sb_q.size() != 0});
    chk("sb_in_ready", {31'h0, in_ready}, {31'h0, sb_q.size() != 2});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;

    //                rst flush iv din       ordy  ov ir od        cnt
    vecs[0]  = mk(1, 0, 1, 16'hBEEF, 0,   0, 1, 16'h0000, 0);
    vecs[1]  = mk(1, 0, 1, 16'hBEEF, 0,   0, 1, 16'h0000, 0);
    vecs[2]  = mk(0, 0, 1, 16'h1234, 0,   1, 1, 16'h1234, 1);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 1,   0, 1, 16'h1234, 0);
    vecs[4]  = mk(0, 0, 1, 16'h12AB, 0,   1, 1, 16'h12AB, 1);
    vecs[5]  = mk(0, 0, 1, 16'h34CD, 0,   1, 0, 16'h12AB, 2);
    vecs[6]  = mk(0, 0, 1, 16'h5555, 0,   1, 0, 16'h12AB, 2);
    vecs[7]  = mk(0, 1, 1, 16'h7777, 1,   0, 1, 16'h00AB, 0);
    vecs[8]  = mk(0, 0, 0, 16'h0000, 0,   0, 1, 16'h00AB, 0);
    vecs[9]  = mk(0, 0, 1, 16'h1111, 0,   1, 1, 16'h1111, 1);
    vecs[10] = mk(0, 0, 1, 16'h2222, 0,   1, 0, 16'h1111, 2);
    vecs[11] = mk(0, 0, 1, 16'h3333, 1,   1, 1, 16'h2222, 1);
    vecs[12] = mk(0, 0, 1, 16'h3333, 1,   1, 1, 16'h3333, 1);
    vecs[13] = mk(0, 0, 0, 16'h0000, 1,   0, 1, 16'h3333, 0);
    vecs[14] = mk(0, 0, 1, 16'hABCD, 0,   1, 1, 16'hABCD, 1);
    vecs[15] = mk(0, 0, 1, 16'hEF01, 0,   1, 0, 16'hABCD, 2);
    vecs[16] = mk(1, 1, 1, 16'h9999, 1,   0, 1, 16'h0000, 0);
    vecs[17] = mk(0, 1, 1, 16'h4242, 1,   0, 1, 16'h0000, 0);

    for (int i = 0; i < 18; i++) begin
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'h0, in_ready},  {31'h0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_out_data", i),  {16'h0, out_data},  {16'h0, vecs[i].exp_od});
      chk($sformatf("vec%0d_count", i),     {30'h0, count},     {30'h0, vecs[i].exp_cnt});
      $display("vec %0d rst=%0b fl=%0b iv=%0b din=%04h ordy=%0b -> ov=%0b ir=%0b od=%04h cnt=%0d",
               i, rst, flush, in_valid, in_data, out_ready, out_valid, in_ready, out_data, count);
    end

    // Back-to-back streaming with the downstream always ready.
    for (int i = 1; i <= 16; i++) sb_step(1'b1, 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) sb_step(1'b0, 16'h0, 1'b1, 1'b0);

    // Three-cycle downstream stall in the middle of a stream.
    for (int i = 0; i < 10; i++) begin
      sb_step(1'b1, 16'hA000 + 16'(i), !(i >= 2 && i < 5), 1'b0);
    end
    for (int i = 0; i < 4; i++) sb_step(1'b0, 16'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      sb_step(1'($urandom_range(0, 1)), 16'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      chk("rand_in_ready_vs_count", {31'h0, in_ready}, {31'h0, count != 2'd2});
    end
    for (int i = 0; i < 4; i++) sb_step(1'b0, 16'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
